register_file_param: RTL and testbench
======================================

Name: register_file_param

Overview:
- Parametrised successor to the CPU's fixed 8-entry general-purpose register file.
- Configurable width and depth, optional hardwired-zero register 0, optional write-to-read bypass, asynchronous clear on reset.
- Has a handshaked sequential dump port that streams every register out for simulation and debug, in place of file dumps from simulation system tasks.
- Sits between the decode stage (read addresses) and the write-back stage (write address/data/enable).

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 3, register address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to the combinational read ports

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
read_reg1  input  ADDR_W  read port 1 address
read_reg2  input  ADDR_W  read port 2 address
read_data1  output  DATA_W  read port 1 data (combinational)
read_data2  output  DATA_W  read port 2 data (combinational)
write_reg  input  ADDR_W  write address
write_data  input  DATA_W  write data
reg_write  input  1  write enable, sampled on rising clk
dump_start  input  1  request a full-register dump; honoured only in IDLE
dump_valid  output  1  dump beat valid
dump_ready  input  1  consumer accepts beat
dump_addr  output  ADDR_W  index of the register in the current beat
dump_data  output  DATA_W  value of the register in the current beat
dump_busy  output  1  high while state != IDLE
dump_done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0.
  - FSM goes to IDLE.
  - dump_valid, dump_done, dump_busy, dump_addr and dump_data go to 0.
  - Reset mid-dump abandons the dump; no dump_done is produced.
- Write:
  - On posedge clk with reg_write=1, registers[write_reg] <= write_data.
  - With ZERO_REG=1, a write to address 0 is dropped.
- Read:
  - Combinational, zero latency: read_dataN = registers[read_regN].
  - With ZERO_REG=1, address 0 returns 0.
  - With BYPASS=1, if reg_write=1, write_reg == read_regN, and the address is not the zero register, then read_dataN = write_data.
  - With BYPASS=0, the read returns the old value until the clock edge.
  - Both ports may address the same register.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE -> SEND when dump_start=1. Pointer is set to 0; dump_addr=0; dump_data latches the value of register 0 after any same-edge write (0 if ZERO_REG). dump_valid goes to 1.
  - SEND, dump_ready=0: dump_addr and dump_data hold stable, even if register[dump_addr] is written meanwhile. The beat shows the value captured at latch time.
  - SEND, dump_valid & dump_ready, pointer < DEPTH-1: pointer increments; dump_data latches the next register's post-edge value (includes a write to that register on the same edge). dump_valid stays 1, giving one beat per cycle when dump_ready is held high.
  - SEND, handshake with pointer == DEPTH-1: go to DONE; dump_valid goes to 0.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
  - dump_start is ignored outside IDLE.
  - Normal reads and writes are never stalled by a dump.
- A full dump with dump_ready tied high takes DEPTH beats plus 1 DONE cycle after the start cycle.
- Pointer arithmetic is ADDR_W bits wide and never wraps during a dump, because DONE is taken at DEPTH-1.

Test Plan:
1. Reset, then read all addresses -> every read_data = 0; dump outputs all 0; dump_busy=0.
2. Write 0xDEADBEEF to r5, next cycle read_reg1=5 -> 0xDEADBEEF. Same-cycle write 0x1234 to r3 with read_reg2=3 -> read_data2=0x1234 during the write cycle (BYPASS=1). With BYPASS=0, the old value is returned until the edge.
3. Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> read r0 = 0 in the write cycle and afterwards, including via bypass.
4. Load rK = K*0x11, pulse dump_start with dump_ready=1 -> 8 beats, addr 0..7, data 0x00,0x11..0x77 (r0=0). dump_done pulses the cycle after beat 7. dump_start is ignored while busy.
5. Dump with dump_ready low while r2 is presented, write r2=0xAAAA -> dump_data stays the old r2 until accepted. Write r3=0xBBBB on the r2 accept edge -> next beat shows 0xBBBB.
6. Deassert rst_n during beat 4 -> registers=0, dump_valid=0 immediately, no dump_done. A new dump_start after release streams all zeros.

Source files
------------

// File: rtl/register_file_param.sv
// Parametrised general-purpose register file with combinational read ports,
// optional hardwired zero register, optional write bypass and a handshaked dump port.
module register_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_valid;

    logic              w_wr_en;
    logic              w_hs;
    logic [ADDR_W-1:0] w_latch_addr;
    logic [DATA_W-1:0] w_latch_data;

    assign w_wr_en = reg_write && !((ZERO_REG != 0) && (write_reg == '0));
    assign w_hs    = r_dump_valid && dump_ready;

    // Value a register holds after the current edge; bypass_en selects whether
    // an in-flight write is visible before the edge.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a,
                                                 input logic bypass_en);
        if ((ZERO_REG != 0) && (a == '0))
            return '0;
        if (bypass_en && w_wr_en && (write_reg == a))
            return write_data;
        return r_regs[a];
    endfunction

    always_comb begin
        read_data1 = f_read(read_reg1, BYPASS != 0);
        read_data2 = f_read(read_reg2, BYPASS != 0);
    end

    always_comb begin
        w_latch_addr = (r_state == S_IDLE) ? '0 : r_ptr + ADDR_W'(1);
        w_latch_data = f_read(w_latch_addr, 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    // Dump handshake: a beat (dump_addr/dump_data) is transferred on a rising
    // edge where dump_valid and dump_ready are both high; while dump_valid is
    // high and dump_ready low the beat is held unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dump_start) begin
                        r_state      <= S_SEND;
                        r_ptr        <= '0;
                        r_dump_data  <= w_latch_data;
                        r_dump_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (r_ptr == LAST_ADDR) begin
                            r_state      <= S_DONE;
                            r_dump_valid <= 1'b0;
                        end else begin
                            r_ptr       <= w_latch_addr;
                            r_dump_data <= w_latch_data;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dump_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_ptr;
    assign dump_data  = r_dump_data;
    assign dump_busy  = (r_state != S_IDLE);
    assign dump_done  = (r_state == S_DONE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: directed steps followed by random traffic,
// checked against an array-based reference model and a dump beat queue.
module tb_register_file_param;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] read_reg1, read_reg2, write_reg;
  logic [DW-1:0] write_data;
  logic          reg_write, dump_start, dump_ready;
  logic [DW-1:0] read_data1, read_data2;
  logic          dump_valid, dump_busy, dump_done;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic [1:0]    dbg_state;

  // second instance: no bypass, no zero register, dump port unused
  logic [DW-1:0] nb_data1, nb_data2, nb_dump_data;
  logic          nb_valid, nb_busy, nb_done;
  logic [AW-1:0] nb_dump_addr;
  logic [1:0]    nb_dbg_state;

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done), .dbg_state(dbg_state)
  );

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(nb_data1), .read_data2(nb_data2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .dump_start(1'b0), .dump_valid(nb_valid), .dump_ready(1'b0),
    .dump_addr(nb_dump_addr), .dump_data(nb_dump_data),
    .dump_busy(nb_busy), .dump_done(nb_done), .dbg_state(nb_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_SEND, M_DONE} mstate_t;

  logic [DW-1:0]    m_regs [DEPTH];
  logic [DW-1:0]    m_nb   [DEPTH];
  mstate_t          m_state;
  int               m_idx;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    beat_log[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_nb[i]   = '0;
    end
    m_state = M_IDLE;
    m_idx   = 0;
    exp_q.delete();
  endtask

  // Architectural read: r0 is zero, a write in flight is visible immediately.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (reg_write && write_reg == a) return write_data;
    return m_regs[a];
  endfunction

  task automatic check_outputs();
    chk("rd1", read_data1, exp_rd(read_reg1));
    chk("rd2", read_data2, exp_rd(read_reg2));
    chk("nb_rd1", nb_data1, m_nb[read_reg1]);
    chk("nb_rd2", nb_data2, m_nb[read_reg2]);
    chk("dump_valid", DW'(dump_valid), DW'(m_state == M_SEND));
    chk("dump_busy", DW'(dump_busy), DW'(m_state != M_IDLE));
    chk("dump_done", DW'(dump_done), DW'(m_state == M_DONE));
    if (m_state == M_SEND && exp_q.size() > 0) begin
      chk("dump_addr", DW'(dump_addr), DW'(exp_q[0][AW+DW-1:DW]));
      chk("dump_data", dump_data, exp_q[0][DW-1:0]);
    end
  endtask

  // One clock: check settled outputs, take the edge, advance the model.
  task automatic cycle();
    logic hs, st;
    #1;
    check_outputs();
    hs = (m_state == M_SEND) && dump_ready;
    st = (m_state == M_IDLE) && dump_start;
    if (hs) beat_log.push_back(dump_data);
    @(posedge clk);
    if (reg_write) begin
      if (write_reg != 0) m_regs[write_reg] = write_data;
      m_nb[write_reg] = write_data;
    end
    case (m_state)
      M_IDLE: if (st) begin
        m_state = M_SEND;
        m_idx   = 0;
        exp_q.push_back({AW'(0), m_regs[0]});
      end
      M_SEND: if (hs) begin
        void'(exp_q.pop_front());
        if (m_idx == DEPTH - 1) m_state = M_DONE;
        else begin
          m_idx++;
          exp_q.push_back({AW'(m_idx), m_regs[m_idx]});
        end
      end
      M_DONE: m_state = M_IDLE;
      default: m_state = M_IDLE;
    endcase
    #1;
  endtask

  task automatic drive_write(input int a, input logic [DW-1:0] d);
    reg_write  = 1'b1;
    write_reg  = AW'(a);
    write_data = d;
  endtask

  task automatic run_to_idle(input int budget);
    int n = 0;
    while (m_state != M_IDLE && n < budget) begin
      cycle();
      n++;
    end
    chk("dump_timeout", DW'(m_state == M_IDLE), DW'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; read_reg1 = '0; read_reg2 = '0; write_reg = '0;
    write_data = '0; reg_write = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // reset state: every address reads zero, dump port idle
    for (int i = 0; i < DEPTH; i++) begin
      read_reg1 = AW'(i);
      read_reg2 = AW'(DEPTH - 1 - i);
      #1;
      check_outputs();
    end
    chk("rst_dump_addr", DW'(dump_addr), '0);
    chk("rst_dump_data", dump_data, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // write then read back; bypass on a same-cycle write
    drive_write(5, 32'hDEAD_BEEF); read_reg1 = 3'd5; cycle();
    reg_write = 1'b0; cycle();
    chk("r5_readback", read_data1, 32'hDEAD_BEEF);
    drive_write(3, 32'h1234); read_reg2 = 3'd3; #1;
    chk("r3_bypass", read_data2, 32'h1234);
    chk("r3_nobypass_old", nb_data2, 32'h0);
    cycle();
    reg_write = 1'b0; cycle();
    chk("r3_nobypass_new", nb_data2, 32'h1234);

    // writes to r0 are dropped, even on the bypass path
    drive_write(0, 32'hFFFF_FFFF); read_reg1 = 3'd0; #1;
    chk("r0_bypass", read_data1, 32'h0);
    cycle();
    reg_write = 1'b0; cycle();
    chk("r0_after", read_data1, 32'h0);

    // full dump with ready tied high; start held to show it is ignored while busy
    for (int k = 0; k < DEPTH; k++) begin
      drive_write(k, DW'(k * 32'h11)); cycle();
    end
    reg_write = 1'b0; dump_ready = 1'b1; dump_start = 1'b1;
    beat_log.delete();
    for (int c = 0; c < DEPTH + 1; c++) begin
      cycle();
      if (c == 2) dump_start = 1'b0;
    end
    chk("done_after_last", DW'(dump_done), DW'(1));
    cycle();
    chk("idle_after_done", DW'(dump_busy), DW'(0));
    chk("beat_count", DW'(beat_log.size()), DW'(DEPTH));
    for (int k = 0; k < DEPTH && k < beat_log.size(); k++)
      chk("dump_seq", beat_log[k], DW'(k * 32'h11));

    // back-pressure: held beat ignores writes, next beat sees same-edge write
    dump_ready = 1'b0; dump_start = 1'b1; cycle();
    dump_start = 1'b0; dump_ready = 1'b1; cycle(); cycle();
    dump_ready = 1'b0; drive_write(2, 32'hAAAA); cycle();
    reg_write = 1'b0; cycle();
    chk("held_r2", dump_data, 32'h22);
    chk("held_addr", DW'(dump_addr), DW'(2));
    dump_ready = 1'b1; drive_write(3, 32'hBBBB); cycle();
    reg_write = 1'b0;
    chk("r3_same_edge", dump_data, 32'hBBBB);
    run_to_idle(20);

    // reset in the middle of beat 4
    dump_ready = 1'b1; dump_start = 1'b1; cycle();
    dump_start = 1'b0;
    repeat (4) cycle();
    chk("beat4_addr", DW'(dump_addr), DW'(4));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("rst_mid_valid", DW'(dump_valid), DW'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    dump_start = 1'b1; beat_log.delete();
    cycle();
    dump_start = 1'b0;
    run_to_idle(20);
    chk("zero_beats", DW'(beat_log.size()), DW'(DEPTH));
    for (int k = 0; k < beat_log.size(); k++)
      chk("zero_dump", beat_log[k], '0);

    // randomized traffic with interleaved dumps and random back-pressure
    for (int c = 0; c < 400; c++) begin
      reg_write  = ($urandom_range(0, 2) != 0);
      write_reg  = AW'($urandom_range(0, DEPTH - 1));
      write_data = $urandom;
      read_reg1  = AW'($urandom_range(0, DEPTH - 1));
      read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, DEPTH - 1));
      dump_start = ($urandom_range(0, 7) == 0);
      dump_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    reg_write = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
    run_to_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
